dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 256x8 data memory (combinational read, write on clk edge).
- Requester 0 is the core load/store path; requester 1 is the auxiliary engine (loader/DMA).
- Registers the winning request, drives the memory port for one cycle, then returns a registered ack and read data.
- Round-robin fairness between the two requesters.

Parameters:
- AW, 8, address width (256-deep memory)
- DW, 8, data width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- req0  input  1  requester 0 access request; held high with we0/addr0/wdata0 stable until ack0
- we0  input  1  requester 0: 1 = write, 0 = read
- addr0  input  AW  requester 0 address
- wdata0  input  DW  requester 0 write data
- ack0  output  1  one-cycle completion pulse to requester 0
- rdata0  output  DW  requester 0 read data; valid while ack0=1
- req1, we1, addr1, wdata1, ack1, rdata1: same as requester 0, for requester 1
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory combinational read data
- busy  output  1  high in ISSUE or RESP

Behaviour:
- Reset values (asynchronous, while reset=0):
  - state=IDLE; ack0=ack1=0; rdata0=rdata1=0.
  - mem_we=0, mem_addr=0, mem_wdata=0; busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE: memory port idle (mem_we=0). If any eligible req, latch winner id, we, addr and wdata into issue registers -> ISSUE. Otherwise stay.
  - ISSUE (1 cycle):
    - mem_addr/mem_wdata driven from the issue registers; mem_we = latched we.
    - Write: memory commits at the clk edge ending ISSUE.
    - Read: mem_rdata captured into rdata of the winner at that same edge; the other rdata holds its value.
    - Always -> RESP.
  - RESP (1 cycle):
    - ack of the winner = 1; mem_we=0.
    - Arbitration is evaluated in the same cycle. If an eligible req exists, latch it -> ISSUE (back-to-back). Otherwise -> IDLE.
- Eligibility:
  - In RESP, the requester being acked is ineligible, since its req is still high that cycle.
  - Requesters must drop req, or present a new request, no earlier than the cycle after ack.
- Arbitration:
  - If only one eligible req, it wins.
  - If both are eligible, the requester != last_grant wins.
  - last_grant updates on every latch (IDLE->ISSUE or RESP->ISSUE).
- Latency and throughput:
  - req sampled in IDLE at cycle N -> ISSUE at N+1 -> ack at N+2.
  - Sustained rate is one access per 2 cycles when requests are back-to-back.
- Outputs:
  - ack is a registered single-cycle pulse; never asserted to both requesters in the same cycle.
  - rdata on a write ack is unspecified but stable (holds its previous value).
- mem_we is high only in ISSUE with a latched write; this makes exactly one memory write per write request.
- A req dropped before its grant is latched is ignored. A req dropped after the latch still completes; the ack is issued and ignored.
- Reset mid-operation: the in-flight access is aborted, with no ack and mem_we low immediately. If reset asserts during ISSUE before the edge, no write occurs.
- Widths: addresses pass through unmodified, with no wrap or offset logic; address 255 is valid.

Test Plan:
- Single read: mem[0x10]=0xA5, req0=1, we0=0, addr0=0x10 in IDLE at cycle N -> mem_addr=0x10 at N+1; ack0=1 and rdata0=0xA5 at N+2; ack1 stays 0.
- Single write then read-back: req1 writes 0x3C to 0xFF -> mem_we=1 for exactly one cycle with mem_addr=0xFF, mem_wdata=0x3C; ack1 two cycles later. A subsequent req1 read of 0xFF -> rdata1=0x3C.
- Simultaneous requests after reset: req0 and req1 both rise in the same cycle -> requester 0 is served first. ack0 is followed 2 cycles later by ack1 (RESP->ISSUE back-to-back), and busy stays high throughout.
- Fairness: req0 and req1 held continuously, each re-requesting the cycle after its ack, for 8 accesses -> acks alternate 0,1,0,1,...; neither requester is acked twice in a row.
- Reset mid-operation: assert reset low during ISSUE of a write of 0x77 to 0x20 -> mem_we=0 immediately; mem[0x20] is unchanged; no ack; after release, state is IDLE and the next tie is won by requester 0.
- Dropped request: req1 pulsed for one cycle while requester 0 is in ISSUE -> req1 is never latched and ack1 never asserts.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port data memory
// between the core load/store path (requester 0) and the auxiliary engine (requester 1).
module dmem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state;
   logic   issue_id;
   logic   last_grant;
   logic   elig0;
   logic   elig1;
   logic   grant_valid;
   logic   grant_id;

   // The requester being acked in RESP still holds req high, so it must not win again.
   always_comb begin
      elig0       = req0 && !(state == RESP && issue_id == 1'b0);
      elig1       = req1 && !(state == RESP && issue_id == 1'b1);
      grant_valid = (state != ISSUE) && (elig0 || elig1);
      if (elig0 && elig1) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = elig1;
      end
   end

   // mem_addr/mem_wdata double as the issue registers; mem_we is the latched write flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         issue_id   <= 1'b0;
         last_grant <= 1'b1;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         mem_we <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (grant_valid) begin
                  state      <= ISSUE;
                  busy       <= 1'b1;
                  issue_id   <= grant_id;
                  last_grant <= grant_id;
                  mem_we     <= grant_id ? we1 : we0;
                  mem_addr   <= grant_id ? addr1 : addr0;
                  mem_wdata  <= grant_id ? wdata1 : wdata0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            ISSUE: begin
               state <= RESP;
               busy  <= 1'b1;
               if (issue_id) begin
                  ack1 <= 1'b1;
               end else begin
                  ack0 <= 1'b1;
               end
               if (!mem_we) begin
                  if (issue_id) begin
                     rdata1 <= mem_rdata;
                  end else begin
                     rdata0 <= mem_rdata;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
